lfsr_bist_engine: RTL and testbench
===================================

Name: lfsr_bist_engine

Overview:
Parametrised LFSR engine for on-chip BIST. It runs in one of two modes:
- Fibonacci PRBS pattern generator (GEN).
- Multiple-input signature register (MISR) that compacts response data.

Width, feedback polynomial and seed are set by parameters. It adds a runtime seed load, step enable, period detection and all-zero lock-up recovery. It sits between the BIST controller and the circuit under test: it feeds patterns in GEN mode and accumulates responses in MISR mode.

Parameters:
WIDTH, 4, register width in bits; legal range 2..32.
TAPS, 4'b1100 (WIDTH bits), feedback mask; bit i set means q[i] is XORed into the feedback.
SEED, 1 (WIDTH bits), reset value and lock-up recovery value; must be nonzero.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
en  in  1  advance one step this cycle.
mode  in  1  0 = GEN, 1 = MISR; sampled on every enabled step.
load  in  1  load seed_in this cycle.
seed_in  in  WIDTH  runtime seed.
data_in  in  WIDTH  MISR response word; ignored in GEN mode.
q  out  WIDTH  current LFSR state (registered).
step_cnt  out  WIDTH  steps taken since the last reset or load (registered).
period_done  out  1  one-cycle pulse when GEN mode returns to the active seed.
lockup  out  1  one-cycle pulse when all-zero recovery fires.

Behaviour:
- Feedback: fb = XOR-reduce(q & TAPS).
- GEN step: next = {q[WIDTH-2:0], fb}.
- MISR step: next = {q[WIDTH-2:0], fb} ^ data_in.
- Internal register act_seed holds the active seed. It is SEED after reset and seed_in after a load.
- Priority per rising edge: reset > load > en > hold.
- reset:
  - q = SEED, act_seed = SEED, step_cnt = 0, period_done = 0, lockup = 0.
  - Applying reset mid-run discards all state.
- load:
  - q = seed_in, act_seed = seed_in, step_cnt = 0; pulses are cleared.
  - seed_in = 0 is accepted; recovery then applies on the next GEN step.
  - load with en high: the load wins and no step occurs.
- en:
  - Latency is 1 cycle: q shows the new state on the edge where en was sampled high.
  - step_cnt increments modulo 2^WIDTH.
- en low: q, step_cnt and act_seed hold; both pulses are 0.
- period_done:
  - Condition: GEN step whose next == act_seed.
  - Effect: period_done = 1 for exactly that cycle, and step_cnt is cleared to 0 instead of incrementing.
  - Never asserted in MISR mode.
- Lock-up (GEN step while q == 0):
  - Effect: next = act_seed, or SEED if act_seed == 0; lockup = 1 for one cycle; step_cnt = 0.
  - period_done is not asserted on that step.
- MISR with q == 0 is legal and has no recovery.
- Mode switch: the new mode takes effect on the next enabled step. q is not altered by the switch itself.
- Maximal-length TAPS gives a period of 2^WIDTH - 1. Non-maximal TAPS is legal; period_done marks whatever cycle results.

Decomposition:
- Package lfsr_bist_pkg holds:
  - mode constants MODE_GEN = 0 and MODE_MISR = 1;
  - a function lfsr_next(q, taps, data, misr) shared by RTL and the bench reference model;
  - recommended maximal tap masks for widths 4, 8, 16 and 32.
- One sub-module, lfsr_period_mon, covers step_cnt, period_done and lock-up detection. The shift register itself stays in the top module.

Test Plan:
1. Reset and GEN run with WIDTH=4, TAPS=1100, SEED=1, reset held 2 cycles, then en=1.
   Required q sequence: 1, 2, 4, 9, 3, 6, D, A, 5, B, 7, F, E, C, 8, 1. period_done pulses only on the 15th step, where step_cnt returns to 0.
2. Enable gating from q=9: en low for 3 cycles, then high.
   Required: q holds 9 and step_cnt holds; the next state is 3.
3. Load priority: load=1, seed_in=A, en=1 in the same cycle.
   Required: q=A, step_cnt=0. The next enabled GEN step gives 5, and period_done fires when the sequence returns to A after 15 steps.
4. MISR from q=1 with data_in = 1, then 3, then 0.
   Required q sequence: 3, 5, B.
5. Lock-up: load seed_in=0, then one GEN step.
   Required: q=SEED=1, lockup pulses for 1 cycle, period_done stays 0.
6. Mid-run reset while in MISR mode at q=B.
   Required: on the next edge q=1, step_cnt=0, both pulses 0. WIDTH=8 with TAPS=B8 gives period_done after 255 steps.

Source files
------------

// File: rtl/lfsr_bist_pkg.sv
// Shared mode encoding, next-state function and recommended maximal-length
// tap masks for the LFSR BIST engine.
package lfsr_bist_pkg;

    typedef enum logic {
        MODE_GEN  = 1'b0,
        MODE_MISR = 1'b1
    } bist_mode_e;

    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    // Operands are right-aligned and zero-extended; the caller keeps the low
    // WIDTH bits, which drops the bit shifted out of the register.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] q,
        input logic [31:0] taps,
        input logic [31:0] data,
        input logic        misr
    );
        logic fb;
        fb = ^(q & taps);
        lfsr_next = {q[30:0], fb} ^ (misr ? data : '0);
    endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Step counter, period detection and all-zero lock-up detection for the
// LFSR BIST engine.
module lfsr_period_mon
    import lfsr_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] nxt_raw,
    input  logic [WIDTH-1:0] act_seed,
    output logic             recover,
    output logic [WIDTH-1:0] step_cnt,
    output logic             period_done,
    output logic             lockup
);

    logic period_hit;

    assign recover    = (mode == MODE_GEN) && (q == '0);
    assign period_hit = (mode == MODE_GEN) && !recover && (nxt_raw == act_seed);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            step_cnt    <= '0;
            period_done <= 1'b0;
            lockup      <= 1'b0;
        end else if (en) begin
            if (recover) begin
                step_cnt    <= '0;
                period_done <= 1'b0;
                lockup      <= 1'b1;
            end else if (period_hit) begin
                step_cnt    <= '0;
                period_done <= 1'b1;
                lockup      <= 1'b0;
            end else begin
                step_cnt    <= step_cnt + WIDTH'(1);
                period_done <= 1'b0;
                lockup      <= 1'b0;
            end
        end else begin
            period_done <= 1'b0;
            lockup      <= 1'b0;
        end
    end

endmodule

// File: rtl/lfsr_bist_engine.sv
// Fibonacci PRBS generator / MISR with runtime seed load, period detection
// and all-zero lock-up recovery.
module lfsr_bist_engine
    import lfsr_bist_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] step_cnt,
    output logic             period_done,
    output logic             lockup
);

    logic [WIDTH-1:0] act_seed;
    logic [WIDTH-1:0] nxt_raw;
    logic [WIDTH-1:0] nxt;
    logic [31:0]      nxt_full;
    logic             recover;
    logic             unused_hi;

    assign nxt_full  = lfsr_next(32'(q), 32'(TAPS), 32'(data_in), mode == MODE_MISR);
    assign nxt_raw   = nxt_full[WIDTH-1:0];
    assign unused_hi = ^nxt_full;

    // A zero active seed would re-enter lock-up, so fall back to SEED.
    assign nxt = recover ? ((act_seed != '0) ? act_seed : SEED) : nxt_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= SEED;
            act_seed <= SEED;
        end else if (load) begin
            q        <= seed_in;
            act_seed <= seed_in;
        end else if (en) begin
            q        <= nxt;
        end
    end

    lfsr_period_mon #(
        .WIDTH(WIDTH)
    ) u_mon (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .en         (en),
        .mode       (mode),
        .q          (q),
        .nxt_raw    (nxt_raw),
        .act_seed   (act_seed),
        .recover    (recover),
        .step_cnt   (step_cnt),
        .period_done(period_done),
        .lockup     (lockup)
    );

endmodule

// File: tb/tb_lfsr_bist_engine.sv
// Directed bench for lfsr_bist_engine: 4-bit GEN/MISR/lock-up scenarios and
// an 8-bit maximal-length period run.
module tb_lfsr_bist_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, mode, load;
    logic [3:0] seed_in, data_in, q, step_cnt;
    logic       period_done, lockup;

    logic       reset8, en8, mode8, load8;
    logic [7:0] seed_in8, data_in8, q8, step_cnt8;
    logic       period_done8, lockup8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    lfsr_bist_engine #(
        .WIDTH(4),
        .TAPS (4'b1100),
        .SEED (4'd1)
    ) dut4 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .load       (load),
        .seed_in    (seed_in),
        .data_in    (data_in),
        .q          (q),
        .step_cnt   (step_cnt),
        .period_done(period_done),
        .lockup     (lockup)
    );

    lfsr_bist_engine #(
        .WIDTH(8),
        .TAPS (8'hB8),
        .SEED (8'd1)
    ) dut8 (
        .clk        (clk),
        .reset      (reset8),
        .en         (en8),
        .mode       (mode8),
        .load       (load8),
        .seed_in    (seed_in8),
        .data_in    (data_in8),
        .q          (q8),
        .step_cnt   (step_cnt8),
        .period_done(period_done8),
        .lockup     (lockup8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0;
        seed_in = '0; data_in = '0;
        reset8 = 1'b1; en8 = 1'b0; mode8 = 1'b0; load8 = 1'b0;
        seed_in8 = '0; data_in8 = '0;

        // Reset held two cycles
        cycle();
        cycle();
        check("rst_q", 32'(q), 32'h1);
        check("rst_cnt", 32'(step_cnt), 32'h0);
        check("rst_pd", 32'(period_done), 32'h0);
        check("rst_lk", 32'(lockup), 32'h0);
        check("rst_q8", 32'(q8), 32'h1);
        reset = 1'b0;
        reset8 = 1'b0;

        // Full 15-step GEN period
        en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            check("gen_q", 32'(q), 32'(seq[i % 15]));
            check("gen_cnt", 32'(step_cnt), 32'(i % 15));
            check("gen_pd", 32'(period_done), 32'(i == 15));
        end

        // Advance to 9, then gate en
        for (int i = 1; i <= 3; i++) cycle();
        check("pre_hold_q", 32'(q), 32'h9);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_q", 32'(q), 32'h9);
            check("hold_cnt", 32'(step_cnt), 32'h3);
            check("hold_pd", 32'(period_done), 32'h0);
        end
        en = 1'b1;
        cycle();
        check("resume_q", 32'(q), 32'h3);
        check("resume_cnt", 32'(step_cnt), 32'h4);

        // Load beats en in the same cycle
        load = 1'b1; seed_in = 4'hA;
        cycle();
        check("load_q", 32'(q), 32'hA);
        check("load_cnt", 32'(step_cnt), 32'h0);
        load = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            check("seedA_q", 32'(q), 32'(seq[(7 + i) % 15]));
            check("seedA_cnt", 32'(step_cnt), 32'(i % 15));
            check("seedA_pd", 32'(period_done), 32'(i == 15));
        end

        // MISR compaction from q=1
        en = 1'b0; load = 1'b1; seed_in = 4'h1;
        cycle();
        load = 1'b0; mode = 1'b1; en = 1'b1;
        data_in = 4'h1;
        cycle();
        check("misr1_q", 32'(q), 32'h3);
        check("misr1_cnt", 32'(step_cnt), 32'h1);
        data_in = 4'h3;
        cycle();
        check("misr2_q", 32'(q), 32'h5);
        data_in = 4'h0;
        cycle();
        check("misr3_q", 32'(q), 32'hB);
        check("misr3_cnt", 32'(step_cnt), 32'h3);
        check("misr3_pd", 32'(period_done), 32'h0);

        // Mid-run reset in MISR mode
        reset = 1'b1; data_in = 4'h5;
        cycle();
        check("mrst_q", 32'(q), 32'h1);
        check("mrst_cnt", 32'(step_cnt), 32'h0);
        check("mrst_pd", 32'(period_done), 32'h0);
        check("mrst_lk", 32'(lockup), 32'h0);
        reset = 1'b0;

        // Zero seed: MISR keeps zero, GEN recovers to SEED
        en = 1'b0; load = 1'b1; seed_in = 4'h0;
        cycle();
        check("zload_q", 32'(q), 32'h0);
        load = 1'b0; mode = 1'b1; data_in = 4'h0; en = 1'b1;
        cycle();
        check("zmisr_q", 32'(q), 32'h0);
        check("zmisr_lk", 32'(lockup), 32'h0);
        check("zmisr_cnt", 32'(step_cnt), 32'h1);
        mode = 1'b0;
        cycle();
        check("lock_q", 32'(q), 32'h1);
        check("lock_lk", 32'(lockup), 32'h1);
        check("lock_pd", 32'(period_done), 32'h0);
        check("lock_cnt", 32'(step_cnt), 32'h0);
        en = 1'b0;
        cycle();
        check("lock_clr", 32'(lockup), 32'h0);
        check("lock_hold_q", 32'(q), 32'h1);

        // Lock-up with nonzero active seed recovers to that seed
        load = 1'b1; seed_in = 4'hA;
        cycle();
        load = 1'b0; mode = 1'b1; data_in = 4'h5; en = 1'b1;
        cycle();
        check("misr_zero_q", 32'(q), 32'h0);
        mode = 1'b0;
        cycle();
        check("lockA_q", 32'(q), 32'hA);
        check("lockA_lk", 32'(lockup), 32'h1);
        check("lockA_pd", 32'(period_done), 32'h0);
        en = 1'b0;

        // 8-bit maximal-length period
        en8 = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            cycle();
            check("w8_pd", 32'(period_done8), 32'(i == 255));
            if (i == 254) check("w8_cnt254", 32'(step_cnt8), 32'd254);
        end
        check("w8_q_end", 32'(q8), 32'h1);
        check("w8_cnt_end", 32'(step_cnt8), 32'h0);
        en8 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
